// File: rtl/lsu_initiator_if.sv
// Core request/response and word-memory signals of the load/store initiator.
// slave = the initiator itself, master = the core + memory side that drives it.
interface lsu_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/lsu_initiator.sv
// Load/store initiator: one core request at a time into word reads/writes, read-modify-write for sb/sh.
// Latency accept->resp: error 2, load 2+RD_LAT, sw 3, sb/sh 3+RD_LAT cycles.
// Backpressure: req_ready only in IDLE; the memory side never stalls.
module lsu_initiator #(
    parameter int MEM_WORDS = 64,
    parameter int RD_LAT    = 1
) (
    input  logic           clk,
    input  logic           reset,
    lsu_initiator_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [2:0]  cnt_q, cnt_d;

    logic f3_ok, misal, range_err, chk_err, is_sw;

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {a, 3'b000};
        b  = sh[7:0];
        h  = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return w;
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return 32'b0;
        endcase
    endfunction

    // Sub-word store: overwrite only the addressed lane of the word just read.
    function automatic logic [31:0] merge(input logic [1:0] size, input logic [1:0] a,
                                          input logic [31:0] w, input logic [31:0] d);
        logic [31:0] mask, ins;
        if (size == 2'b00) begin
            mask = 32'h0000_00FF << {a, 3'b000};
            ins  = {24'b0, d[7:0]} << {a, 3'b000};
        end else if (size == 2'b01) begin
            mask = 32'h0000_FFFF << {a[1], 4'b0000};
            ins  = {16'b0, d[15:0]} << {a[1], 4'b0000};
        end else begin
            mask = 32'hFFFF_FFFF;
            ins  = d;
        end
        return (w & ~mask) | (ins & mask);
    endfunction

    always_comb begin
        f3_ok     = write_q ? (f3_q inside {3'b000, 3'b001, 3'b010})
                            : (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misal     = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                    ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        range_err = {2'b00, addr_q[31:2]} >= 32'(MEM_WORDS);
        chk_err   = !f3_ok || misal || range_err;
        is_sw     = write_q && (f3_q[1:0] == 2'b10);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            word_q  <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
            cnt_q   <= 3'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        f3_d          = f3_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        word_d        = word_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_wdata = 32'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    state_d = READ;
                end
            end
            READ: begin
                err_d = chk_err;
                if (chk_err) begin
                    rdata_d = 32'b0;
                    state_d = RESP;
                end else if (!is_sw) begin
                    bus.mem_read = 1'b1;
                    cnt_d        = 3'(RD_LAT - 1);
                    state_d      = WAIT;
                end else begin
                    state_d = WRITE;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (write_q) begin
                        word_d  = bus.mem_rdata;
                        state_d = WRITE;
                    end else begin
                        rdata_d = extract(f3_q, addr_q[1:0], bus.mem_rdata);
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WRITE: begin
                bus.mem_write = 1'b1;
                bus.mem_wdata = is_sw ? wdata_q : merge(f3_q[1:0], addr_q[1:0], word_q, wdata_q);
                rdata_d       = 32'b0;
                state_d       = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = (state_q == RESP) && err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_addr   = (state_q inside {READ, WAIT, WRITE}) ? {addr_q[31:2], 2'b00} : 32'b0;
endmodule

// File: tb/tb_lsu_initiator.sv
// Scoreboard bench for lsu_initiator: RD_LAT=1 and RD_LAT=3 instances, each with a word-memory model.
module tb_lsu_initiator;
    typedef struct packed {
        int          acc;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          nrd;
        int          nwr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    lsu_initiator_if b0();
    lsu_initiator_if b1();

    lsu_initiator #(.MEM_WORDS(64), .RD_LAT(1)) u0 (.clk(clk), .reset(rst_n), .bus(b0));
    lsu_initiator #(.MEM_WORDS(64), .RD_LAT(3)) u1 (.clk(clk), .reset(rst_n), .bus(b1));

    logic        dv[2], dw[2];
    logic [2:0]  df[2];
    logic [31:0] da[2], dd[2];
    assign b0.req_valid = dv[0];  assign b1.req_valid = dv[1];
    assign b0.req_write = dw[0];  assign b1.req_write = dw[1];
    assign b0.req_funct3 = df[0]; assign b1.req_funct3 = df[1];
    assign b0.req_addr = da[0];   assign b1.req_addr = da[1];
    assign b0.req_wdata = dd[0];  assign b1.req_wdata = dd[1];

    logic        rr[2], rv[2], re[2], mr[2], mw[2];
    logic [31:0] rd[2], ma[2], mwd[2];
    assign rr[0] = b0.req_ready;  assign rr[1] = b1.req_ready;
    assign rv[0] = b0.resp_valid; assign rv[1] = b1.resp_valid;
    assign re[0] = b0.resp_err;   assign re[1] = b1.resp_err;
    assign rd[0] = b0.resp_rdata; assign rd[1] = b1.resp_rdata;
    assign mr[0] = b0.mem_read;   assign mr[1] = b1.mem_read;
    assign mw[0] = b0.mem_write;  assign mw[1] = b1.mem_write;
    assign ma[0] = b0.mem_addr;   assign ma[1] = b1.mem_addr;
    assign mwd[0] = b0.mem_wdata; assign mwd[1] = b1.mem_wdata;

    // Memory models: read data shows up RD_LAT cycles after the mem_read cycle.
    logic [31:0] mem0[64], mem1[64];
    logic [31:0] rp0[4], rp1[4];
    logic        pre_en[2];
    logic [5:0]  pre_idx;
    logic [31:0] pre_dat;
    always @(posedge clk) begin
        rp0[0] <= b0.mem_read ? mem0[b0.mem_addr[7:2]] : 32'h0;
        rp1[0] <= b1.mem_read ? mem1[b1.mem_addr[7:2]] : 32'h0;
        for (int i = 1; i < 4; i++) begin
            rp0[i] <= rp0[i-1];
            rp1[i] <= rp1[i-1];
        end
        if (b0.mem_write) mem0[b0.mem_addr[7:2]] <= b0.mem_wdata;
        if (b1.mem_write) mem1[b1.mem_addr[7:2]] <= b1.mem_wdata;
        if (pre_en[0]) mem0[pre_idx] <= pre_dat;
        if (pre_en[1]) mem1[pre_idx] <= pre_dat;
    end
    assign b0.mem_rdata = rp0[0];
    assign b1.mem_rdata = rp1[2];

    exp_t sbq[2][$];
    int   nrd[2], nwr[2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    nrd[k] = 0;
                    nwr[k] = 0;
                end else begin
                    if (mr[k] || mw[k]) begin
                        check("rw_exclusive", 32'(mr[k] & mw[k]), 32'd0);
                        if (sbq[k].size() == 0) check("stray_strobe", 32'(sbq[k].size()), 32'd1);
                        else begin
                            check("mem_addr", ma[k], sbq[k][0].addr);
                            if (mr[k]) nrd[k]++;
                            if (mw[k]) begin
                                nwr[k]++;
                                check("mem_wdata", mwd[k], sbq[k][0].wdata);
                            end
                        end
                    end
                    if (rv[k]) begin
                        if (sbq[k].size() == 0) check("stray_resp", 32'(sbq[k].size()), 32'd1);
                        else begin
                            e = sbq[k].pop_front();
                            check("resp_err", 32'(re[k]), 32'(e.err));
                            check("resp_rdata", rd[k], e.rdata);
                            check("latency", cyc - e.acc, e.lat);
                            check("read_strobes", nrd[k], e.nrd);
                            check("write_strobes", nwr[k], e.nwr);
                            nrd[k] = 0;
                            nwr[k] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic preload(input int k, input logic [5:0] idx, input logic [31:0] dat);
        pre_idx = idx;
        pre_dat = dat;
        pre_en[k] = 1'b1;
        @(negedge clk);
        pre_en[k] = 1'b0;
    endtask

    // Called at a negedge; leaves req_valid high so a back-to-back issue keeps it asserted.
    task automatic issue(input int k, input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic err, input logic [31:0] rdat,
                         input int lat, input int nr, input int nw, input logic [31:0] wd,
                         output int gap);
        exp_t e;
        int   n = 0;
        dw[k] = w; df[k] = f; da[k] = a; dd[k] = d; dv[k] = 1'b1;
        while (!rr[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        gap = n;
        if (!rr[k]) check("accept_timeout", 32'(rr[k]), 32'd1);
        e.acc = cyc; e.lat = lat; e.err = err; e.rdata = rdat;
        e.nrd = nr; e.nwr = nw; e.addr = {a[31:2], 2'b00}; e.wdata = wd;
        sbq[k].push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        int n = 0;
        dv[k] = 1'b0;
        while (sbq[k].size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sbq[k].size()), 32'd0);
        sbq[k].delete();
        @(negedge clk);
    endtask

    int g;

    initial begin
        dv = '{1'b0, 1'b0}; dw = '{1'b0, 1'b0}; df = '{3'd0, 3'd0};
        da = '{32'd0, 32'd0}; dd = '{32'd0, 32'd0};
        pre_en = '{1'b0, 1'b0}; pre_idx = 6'd0; pre_dat = 32'd0;
        nrd = '{0, 0}; nwr = '{0, 0};
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(rr[0]), 32'd1);
        check("rst_resp_valid", 32'(rv[0]), 32'd0);
        check("rst_resp_err", 32'(re[0]), 32'd0);
        check("rst_resp_rdata", rd[0], 32'd0);
        check("rst_mem_read", 32'(mr[0]), 32'd0);
        check("rst_mem_write", 32'(mw[0]), 32'd0);
        check("rst_mem_addr", ma[0], 32'd0);
        check("rst_mem_wdata", mwd[0], 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        preload(0, 6'd4, 32'h8899AABB);
        preload(1, 6'd4, 32'h8899AABB);

        // loads over 0x8899AABB
        issue(0, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFF88, 3, 1, 0, 32'h0, g); idle(0);
        issue(0, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h00000088, 3, 1, 0, 32'h0, g); idle(0);
        issue(0, 1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'hFFFFAABB, 3, 1, 0, 32'h0, g); idle(0);
        issue(0, 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h00008899, 3, 1, 0, 32'h0, g); idle(0);

        // sb read-modify-write
        issue(0, 1'b1, 3'b000, 32'h11, 32'h123456CC, 1'b0, 32'h0, 4, 1, 1, 32'h8899CCBB, g); idle(0);
        check("sb_mem_word", mem0[4], 32'h8899CCBB);

        // sw then lw with req_valid held across both
        issue(0, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 1'b0, 32'h0, 3, 0, 1, 32'hDEADBEEF, g);
        issue(0, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hDEADBEEF, 3, 1, 0, 32'h0, g);
        check("ready_gap", g, 32'd3);
        idle(0);

        // rejected accesses
        issue(0, 1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0, 2, 0, 0, 32'h0, g); idle(0);
        issue(0, 1'b1, 3'b001, 32'h11, 32'h5555, 1'b1, 32'h0, 2, 0, 0, 32'h0, g); idle(0);
        issue(0, 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 2, 0, 0, 32'h0, g); idle(0);
        issue(0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 32'h0, 2, 0, 0, 32'h0, g); idle(0);

        // sh on both latencies
        preload(0, 6'd4, 32'h8899AABB);
        issue(0, 1'b1, 3'b001, 32'h12, 32'h0000BEEF, 1'b0, 32'h0, 4, 1, 1, 32'hBEEFAABB, g); idle(0);
        check("sh_mem_word", mem0[4], 32'hBEEFAABB);
        issue(1, 1'b1, 3'b001, 32'h12, 32'h0000BEEF, 1'b0, 32'h0, 6, 1, 1, 32'hBEEFAABB, g); idle(1);
        issue(1, 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000BEEF, 5, 1, 0, 32'h0, g); idle(1);
        issue(1, 1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFFFFBB, 5, 1, 0, 32'h0, g); idle(1);

        // reset in the middle of an sb
        preload(0, 6'd4, 32'h8899AABB);
        issue(0, 1'b1, 3'b000, 32'h11, 32'h000000CC, 1'b0, 32'h0, 4, 1, 1, 32'h8899CCBB, g);
        dv[0] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_read", 32'(mr[0]), 32'd0);
        check("arst_mem_write", 32'(mw[0]), 32'd0);
        check("arst_resp_valid", 32'(rv[0]), 32'd0);
        check("arst_mem_addr", ma[0], 32'd0);
        sbq[0].delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(rr[0]), 32'd1);
        check("post_rst_mem_word", mem0[4], 32'h8899AABB);
        issue(0, 1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'hFFFFFFAA, 3, 1, 0, 32'h0, g); idle(0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
